led_scan_scheduler: RTL and testbench
=====================================

# led_scan_scheduler

Sequences the shared row/column drive of the bicolour 8x8 LED matrix. Time-multiplexes eight columns across two colour planes (x, y) and gates each column slot for brightness. Frame-synchronises display commands from the SPI byte receiver so that a mode, pattern or brightness change never tears a frame. Advances the scroll animation position. Sits between the SPI byte assembler and the pattern decoders and column/row FSMs, replacing their free-running dividers.

## Interface
- TICK_DIV, 16384: clk cycles per column slot; must be a multiple of 4 and at least 8.
- STEP_FRAMES, 16: frames per scroll-animation step; must be at least 1.

- clk  in  1  system clock (internal oscillator).
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command byte valid from SPI byte assembler.
- cmd  in  8  command byte:
  - [7:6] brightness level 0..3.
  - [5] static mode.
  - [4:0] static frame index.
  - [0] also selects sun (1) or moon (0) in scroll mode.
- cmd_ready  out  1  pending buffer empty; command accepted when cmd_valid and cmd_ready.
- col_idx  out  3  column currently driven.
- plane  out  1  0 = x plane, 1 = y plane.
- col_en  out  1  column drive enable (brightness gate).
- static_mode  out  1  active cmd[5].
- scroll_sel  out  1  active cmd[0].
- frame_idx  out  5  static mode: active cmd[4:0]; scroll mode: {1'b0, pos}.
- frame_start  out  1  one-cycle pulse in the first cycle of each frame.

## Operation
- Slot counter cnt runs 0..TICK_DIV-1, then wraps.
- Slot number slot runs 0..15 and advances when cnt wraps.
  - col_idx = slot[3:1].
  - plane = slot[0].
  - Order: col0/x, col0/y, col1/x, ... col7/y.
- col_en = (cnt < (level+1)*(TICK_DIV/4)), where level is active[7:6].
  - Level 3 keeps col_en high for the whole slot.
- Frame boundary: the cycle with slot==15 and cnt==TICK_DIV-1.
- Registers:
  - pending: 8-bit data plus a valid flag.
  - active: 8 bits.
  - pos: 4 bits.
  - fcnt: counts 0..STEP_FRAMES-1.
- cmd_ready = !pending_valid. An accepted cmd is written into pending and pending_valid is set.
- At a frame boundary with pending_valid set:
  - active <= pending and pending_valid is cleared.
  - If the new cmd[5] or cmd[0] differs from the current active value, pos <= 0 and fcnt <= 0, overriding the step logic below.
- At a frame boundary in scroll mode, if not cleared as above:
  - fcnt increments.
  - When fcnt == STEP_FRAMES-1, fcnt <= 0 and pos <= pos+1 mod 16 (15 wraps to 0).
- In static mode, pos and fcnt hold.
- A command accepted in the boundary cycle itself goes into pending and is applied at the next boundary, not the current one.
- While pending is full, a new cmd_valid is ignored (no overwrite). The sender holds cmd_valid.
- Reset values:
  - cnt=0, slot=0, active=8'h00 (scroll, moon, level 0), pending_valid=0, pos=0, fcnt=0.
  - Outputs: cmd_ready=1, col_idx=0, plane=0, col_en=1 (cnt 0 < TICK_DIV/4), static_mode=0, scroll_sel=0, frame_idx=0, frame_start=0.

## Timing
- One frame = 16*TICK_DIV cycles.
- frame_start is registered: high in the cycle after each frame boundary (cnt==0, slot==0); low after reset until the first boundary.
- Command latency: 1 cycle from acceptance to cmd_ready low. Applied active values are visible in the first cycle of the next frame, i.e. the same cycle as frame_start.
- cmd_ready returns high in the first cycle of the next frame.
- All outputs besides frame_start decode combinationally from registers; there are no glitch paths from cmd.
- Reset asserted mid-frame returns all state to the reset values immediately and discards pending. Counting resumes on the first clk edge after release.

## Test plan
All scenarios use TICK_DIV=8 and STEP_FRAMES=2, so a frame is 128 cycles.
- Reset release, then 128 cycles:
  - col_idx/plane step (0,0),(0,1),(1,0)...(7,1), 8 cycles each.
  - col_en is high for cnt 0..1 only.
  - frame_start pulses at cycle 128.
- Send cmd=8'hE5 (level 3, static, idx 5) at cycle 10:
  - cmd_ready low at cycle 11.
  - static_mode=1 and frame_idx=5 at cycle 128.
  - col_en high for all 8 cycles of every slot.
  - cmd_ready high at cycle 128.
- Scroll, cmd=8'h01 applied:
  - pos increments every 2 frames: frame_idx 0,0,1,1,...,15,15,0.
  - scroll_sel=1.
- Back-to-back commands 8'h41 then 8'h80 with cmd_valid held:
  - Second is accepted only after the first is applied.
  - 8'h80 becomes active one frame later.
  - pos and fcnt clear because scroll_sel changes 1 to 0.
- cmd_valid pulse exactly in the boundary cycle (cycle 127): applied at cycle 256, not 128.
- Reset asserted at cycle 300 with pending full:
  - All outputs return to reset values asynchronously.
  - The pending command is never applied.

Source files
------------

// File: rtl/led_scan_if.sv
// Command handshake and column/row drive bundle between the scan scheduler and its neighbours.
interface led_scan_if;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       cmd_ready;
    logic [2:0] col_idx;
    logic       plane;
    logic       col_en;
    logic       static_mode;
    logic       scroll_sel;
    logic [4:0] frame_idx;
    logic       frame_start;

    modport slave (
        input  cmd_valid, cmd,
        output cmd_ready, col_idx, plane, col_en, static_mode, scroll_sel, frame_idx, frame_start
    );

    modport master (
        output cmd_valid, cmd,
        input  cmd_ready, col_idx, plane, col_en, static_mode, scroll_sel, frame_idx, frame_start
    );
endinterface

// File: rtl/led_scan_scheduler.sv
// LED matrix scan scheduler: column/plane slot sequencing, brightness gate, frame-synchronous commands, scroll step.
// Latency: cmd_ready drops 1 cycle after accept; command takes effect in the first cycle of the next frame.
// Backpressure: one-deep pending buffer; cmd_ready stays low until the buffered command is applied.
module led_scan_scheduler #(
    parameter int TICK_DIV    = 16384,
    parameter int STEP_FRAMES = 16
) (
    input  logic        clk,
    input  logic        reset,
    led_scan_if.slave   bus
);
    localparam int CW = $clog2(TICK_DIV);
    localparam int FW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int Q  = TICK_DIV / 4;

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_slot;
    logic [7:0]    r_pend;
    logic          r_pend_vld;
    logic [7:0]    r_act;
    logic [3:0]    r_pos;
    logic [FW-1:0] r_fcnt;
    logic          r_frame_start;

    logic          w_cnt_wrap;
    logic          w_boundary;
    logic          w_accept;
    logic          w_mode_chg;
    logic          w_step_last;
    logic [CW:0]   w_thresh;

    assign w_cnt_wrap  = (r_cnt == CW'(TICK_DIV - 1));
    assign w_boundary  = w_cnt_wrap && (r_slot == 4'd15);
    assign w_accept    = bus.cmd_valid && !r_pend_vld;
    assign w_mode_chg  = r_pend_vld && ((r_pend[5] ^ r_act[5]) || (r_pend[0] ^ r_act[0]));
    assign w_step_last = (r_fcnt == FW'(STEP_FRAMES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_slot <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt  <= '0;
            r_slot <= r_slot + 4'd1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    // Apply happens only at the boundary; an accept in that same cycle lands in pending for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_act      <= '0;
        end else if (w_boundary && r_pend_vld) begin
            r_act      <= r_pend;
            r_pend_vld <= 1'b0;
        end else if (w_accept) begin
            r_pend     <= bus.cmd;
            r_pend_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pos  <= '0;
            r_fcnt <= '0;
        end else if (w_boundary) begin
            if (w_mode_chg) begin
                r_pos  <= '0;
                r_fcnt <= '0;
            end else if (!r_act[5]) begin
                if (w_step_last) begin
                    r_fcnt <= '0;
                    r_pos  <= r_pos + 4'd1;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
        end
    end

    always_comb begin
        w_thresh = (CW+1)'(Q);
        case (r_act[7:6])
            2'd0:    w_thresh = (CW+1)'(Q);
            2'd1:    w_thresh = (CW+1)'(2 * Q);
            2'd2:    w_thresh = (CW+1)'(3 * Q);
            default: w_thresh = (CW+1)'(4 * Q);
        endcase
    end

    assign bus.cmd_ready   = !r_pend_vld;
    assign bus.col_idx     = r_slot[3:1];
    assign bus.plane       = r_slot[0];
    assign bus.col_en      = ({1'b0, r_cnt} < w_thresh);
    assign bus.static_mode = r_act[5];
    assign bus.scroll_sel  = r_act[0];
    assign bus.frame_idx   = r_act[5] ? r_act[4:0] : {1'b0, r_pos};
    assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_led_scan_scheduler.sv
// Bench for led_scan_scheduler: directed command scenarios plus random traffic against a frame-level model.
module tb_led_scan_scheduler;
    localparam int TD    = 8;
    localparam int SF    = 2;
    localparam int FRAME = 16 * TD;

    logic clk;
    logic reset;
    led_scan_if bus();

    led_scan_scheduler #(.TICK_DIV(TD), .STEP_FRAMES(SF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: cycles since reset release plus the spec-level registers.
    int         m_t;
    logic [7:0] m_pend;
    bit         m_pv;
    logic [7:0] m_act;
    int         m_pos;
    int         m_fc;
    bit         m_fs;
    int         q_t[$];
    logic [7:0] q_c[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, m_t, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_pend = 8'h00; m_pv = 0; m_act = 8'h00;
        m_pos = 0; m_fc = 0; m_fs = 0;
        q_t.delete(); q_c.delete();
    endtask

    task automatic model_edge();
        bit bnd;
        bit acc;
        bnd = ((m_t % FRAME) == FRAME - 1);
        acc = (bus.cmd_valid === 1'b1) && !m_pv;
        if (bnd) begin
            if (m_pv && ((m_pend[5] != m_act[5]) || (m_pend[0] != m_act[0]))) begin
                m_pos = 0; m_fc = 0;
            end else if (!m_act[5]) begin
                if (m_fc == SF - 1) begin
                    m_fc = 0; m_pos = (m_pos + 1) % 16;
                end else begin
                    m_fc = m_fc + 1;
                end
            end
            if (m_pv) begin
                m_act = m_pend; m_pv = 0;
            end
        end
        if (acc) begin
            m_pend = bus.cmd; m_pv = 1;
            void'(q_t.pop_front());
            void'(q_c.pop_front());
        end
        m_fs = bnd;
        m_t  = m_t + 1;
    endtask

    task automatic compare_all();
        int cnt;
        int slot;
        int lvl;
        cnt  = m_t % TD;
        slot = (m_t / TD) % 16;
        lvl  = int'(m_act[7:6]);
        check("cmd_ready",   32'(bus.cmd_ready),   32'(!m_pv));
        check("col_idx",     32'(bus.col_idx),     32'(slot / 2));
        check("plane",       32'(bus.plane),       32'(slot % 2));
        check("col_en",      32'(bus.col_en),      32'(cnt < (lvl + 1) * (TD / 4)));
        check("static_mode", 32'(bus.static_mode), 32'(m_act[5]));
        check("scroll_sel",  32'(bus.scroll_sel),  32'(m_act[0]));
        check("frame_idx",   32'(bus.frame_idx),   m_act[5] ? 32'(m_act[4:0]) : 32'(m_pos));
        check("frame_start", 32'(bus.frame_start), 32'(m_fs));
    endtask

    task automatic drive();
        if (q_t.size() > 0 && m_t >= q_t[0]) begin
            bus.cmd_valid = 1'b1;
            bus.cmd       = q_c[0];
        end else begin
            bus.cmd_valid = 1'b0;
            bus.cmd       = 8'($urandom);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        drive();
    endtask

    task automatic run_until(input int tend);
        while (m_t < tend) cyc();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"},   32'(bus.cmd_ready),   32'd1);
        check({pfx, "_col_idx"},     32'(bus.col_idx),     32'd0);
        check({pfx, "_plane"},       32'(bus.plane),       32'd0);
        check({pfx, "_col_en"},      32'(bus.col_en),      32'd1);
        check({pfx, "_static_mode"}, 32'(bus.static_mode), 32'd0);
        check({pfx, "_scroll_sel"},  32'(bus.scroll_sel),  32'd0);
        check({pfx, "_frame_idx"},   32'(bus.frame_idx),   32'd0);
        check({pfx, "_frame_start"}, 32'(bus.frame_start), 32'd0);
    endtask

    initial begin
        int t;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("rst_rel");
        compare_all();

        // Static level-3 command sent at cycle 10, then scroll/sun which runs through a full pos wrap.
        q_t.push_back(10);  q_c.push_back(8'hE5);
        q_t.push_back(130); q_c.push_back(8'h01);
        drive();
        run_until(11);
        check("ready_low_c11", 32'(bus.cmd_ready), 32'd0);
        run_until(128);
        check("static_c128", 32'(bus.static_mode), 32'd1);
        check("fidx5_c128",  32'(bus.frame_idx),   32'd5);
        run_until(256 + 33 * FRAME);

        // Back-to-back with cmd_valid held; second clears pos because scroll_sel drops.
        q_t.push_back(4500); q_c.push_back(8'h41);
        q_t.push_back(4500); q_c.push_back(8'h80);
        run_until(4620);
        check("b2b_second_waits", 32'(bus.cmd_ready), 32'd0);
        run_until(4736);
        check("b2b_sel0", 32'(bus.scroll_sel), 32'd0);
        check("b2b_pos0", 32'(bus.frame_idx),  32'd0);

        // Single pulse exactly in a boundary cycle: must wait a whole extra frame.
        q_t.push_back(40 * FRAME - 1); q_c.push_back(8'h3A);
        run_until(40 * FRAME + 1);
        check("bnd_not_applied", 32'(bus.static_mode), 32'd0);
        run_until(41 * FRAME);
        check("bnd_applied", 32'(bus.frame_idx), 32'h1A);

        // Random command traffic with random spacing.
        t = 41 * FRAME + 50;
        for (int i = 0; i < 30; i++) begin
            t += int'($urandom_range(20, 400));
            q_t.push_back(t);
            q_c.push_back(8'($urandom));
        end
        run_until(t + 3 * FRAME);

        // Fill pending mid-frame, then assert reset asynchronously.
        while ((m_t % FRAME) != 20) cyc();
        q_t.push_back(m_t); q_c.push_back(8'hFF);
        drive();
        repeat (5) cyc();
        check("pend_full", 32'(bus.cmd_ready), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        bus.cmd_valid = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        compare_all();
        drive();
        run_until(3 * FRAME + 10);
        check("discarded_static", 32'(bus.static_mode), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
